// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and helpers for the framed UART receiver.
//   parity_mode_t : parity selection for the receiver (NONE, EVEN, ODD)
//   rx_state_t    : receive FSM states
//   majority3     : 2-of-3 vote used on the bit-centre samples
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        NONE,
        EVEN,
        ODD
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//   Front end of the UART receiver: 2-flop synchroniser on the async line,
//   bit timer counting 0..ticks_per_bit-1, and a 3-tap majority vote taken at
//   counts mid-1, mid, mid+1 (mid = ticks_per_bit/2).
// Ports
//   clock        in   system clock
//   resetn       in   asynchronous active-low reset
//   signal       in   async serial line, idle high
//   restart      in   hold the bit timer at 0 (FSM idle / waiting)
//   line_synced  out  synchronised line
//   sample_valid out  one-cycle strobe at count mid+1
//   sample_bit   out  majority of the three centre samples, valid with strobe
// ---------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned ticks_per_bit = 48
) (
    input  logic clock,
    input  logic resetn,
    input  logic signal,
    input  logic restart,
    output logic line_synced,
    output logic sample_valid,
    output logic sample_bit
);

    localparam int unsigned CW  = $clog2(ticks_per_bit);
    localparam int unsigned MID = ticks_per_bit / 2;

    localparam logic [CW-1:0] LAST_COUNT = CW'(ticks_per_bit - 1);
    localparam logic [CW-1:0] TAP_EARLY  = CW'(MID - 1);
    localparam logic [CW-1:0] TAP_MID    = CW'(MID);
    localparam logic [CW-1:0] TAP_LATE   = CW'(MID + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;
    logic          tap_early;
    logic          tap_mid;

    // Synchroniser resets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= signal;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (restart || count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tap_early <= 1'b1;
            tap_mid   <= 1'b1;
        end else begin
            if (count == TAP_EARLY) tap_early <= sync2;
            if (count == TAP_MID)   tap_mid   <= sync2;
        end
    end

    // Third vote is the live synced line in the mid+1 cycle itself.
    assign line_synced  = sync2;
    assign sample_valid = (count == TAP_LATE);
    assign sample_bit   = majority3(tap_early, tap_mid, sync2);

endmodule

// File: rtl/uart_rx_framed.sv
// ---------------------------------------------------------------------------
// uart_rx_framed
//   UART receiver with parametrised width, optional parity and 1/2 stop bits.
//   Holds one received word behind a valid/ready handshake; a frame that
//   completes while a word is still held is dropped and flagged by overrun.
// Ports
//   clock                  in   system clock
//   resetn                 in   asynchronous active-low reset
//   signal                 in   async serial line, idle high
//   data                   out  received word, valid while ready=1
//   ready                  out  word held and valid
//   can_receive_next_word  in   consumer accept
//   parity_error           out  parity mismatch for the held word
//   framing_error          out  a stop bit sampled 0 for the held word
//   overrun                out  one-cycle pulse when a completed frame is dropped
// ---------------------------------------------------------------------------
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int unsigned  width       = 8,
    parameter int unsigned  baud_rate   = 9600,
    parameter int unsigned  clock_freq  = 460800,
    parameter parity_mode_t parity_mode = NONE,
    parameter int unsigned  stop_bits   = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             signal,
    output logic [width-1:0] data,
    output logic             ready,
    input  logic             can_receive_next_word,
    output logic             parity_error,
    output logic             framing_error,
    output logic             overrun
);

    localparam int unsigned TICKS_PER_BIT = clock_freq / baud_rate;

    if (TICKS_PER_BIT < 8) begin : g_bad_ticks
        $error("uart_rx_framed: clock_freq/baud_rate must be at least 8");
    end
    if (width < 5 || width > 9) begin : g_bad_width
        $error("uart_rx_framed: width must be 5..9");
    end
    if (stop_bits < 1 || stop_bits > 2) begin : g_bad_stop
        $error("uart_rx_framed: stop_bits must be 1 or 2");
    end

    localparam logic [3:0] LAST_DATA_BIT = 4'(width - 1);
    localparam logic       LAST_STOP_BIT = 1'(stop_bits - 1);

    rx_state_t        state;
    rx_state_t        next_state;

    logic             line_synced;
    logic             sample_valid;
    logic             sample_bit;
    logic             restart;
    logic             frame_done;
    logic             frame_fe;

    logic [width-1:0] shreg;
    logic [3:0]       bit_cnt;
    logic             par_acc;
    logic             par_err;
    logic             stop_cnt;
    logic             frm_err;

    uart_rx_sampler #(
        .ticks_per_bit(TICKS_PER_BIT)
    ) u_sampler (
        .clock       (clock),
        .resetn      (resetn),
        .signal      (signal),
        .restart     (restart),
        .line_synced (line_synced),
        .sample_valid(sample_valid),
        .sample_bit  (sample_bit)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!line_synced) next_state = START;
            end
            START: begin
                if (sample_valid) next_state = sample_bit ? IDLE : DATA;
            end
            DATA: begin
                if (sample_valid && bit_cnt == LAST_DATA_BIT)
                    next_state = (parity_mode != NONE) ? PARITY : STOP;
            end
            PARITY: begin
                if (sample_valid) next_state = STOP;
            end
            STOP: begin
                if (frame_done) next_state = frame_fe ? WAIT_HIGH : IDLE;
            end
            WAIT_HIGH: begin
                if (line_synced) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        restart    = 1'b0;
        frame_done = 1'b0;
        // Framing flag includes the stop bit being sampled right now.
        frame_fe   = frm_err | ~sample_bit;
        case (state)
            IDLE, WAIT_HIGH: restart = 1'b1;
            STOP:            frame_done = sample_valid && (stop_cnt == LAST_STOP_BIT);
            default:         restart = 1'b0;
        endcase
    end

    // ---------------- Frame datapath ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            par_acc  <= 1'b0;
            par_err  <= 1'b0;
            stop_cnt <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    par_acc  <= 1'b0;
                    par_err  <= 1'b0;
                    stop_cnt <= 1'b0;
                    frm_err  <= 1'b0;
                end
                DATA: begin
                    if (sample_valid) begin
                        shreg   <= {sample_bit, shreg[width-1:1]};
                        par_acc <= par_acc ^ sample_bit;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                PARITY: begin
                    if (sample_valid) begin
                        if (parity_mode == EVEN) par_err <= par_acc ^ sample_bit;
                        else                     par_err <= ~(par_acc ^ sample_bit);
                    end
                end
                STOP: begin
                    if (sample_valid) begin
                        frm_err  <= frm_err | ~sample_bit;
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- Output / handshake register ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data          <= '0;
            ready         <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                // A consume on the completion edge frees the slot for the new word.
                if (!ready || can_receive_next_word) begin
                    data          <= shreg;
                    parity_error  <= par_err;
                    framing_error <= frame_fe;
                    ready         <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (ready && can_receive_next_word) begin
                ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
module tb_uart_rx_framed;
    import uart_pkg::*;

    localparam int TPB = 48;

    logic       clock = 1'b0;
    logic       resetn;
    logic       line_a, line_b;
    logic       acc_a, acc_b;
    logic [7:0] data_a;
    logic [4:0] data_b;
    logic       rdy_a, rdy_b, pe_a, pe_b, fe_a, fe_b, ov_a, ov_b;

    always #5 clock = ~clock;

    uart_rx_framed #(
        .width(8), .baud_rate(9600), .clock_freq(460800),
        .parity_mode(EVEN), .stop_bits(1)
    ) dut_a (
        .clock(clock), .resetn(resetn), .signal(line_a), .data(data_a),
        .ready(rdy_a), .can_receive_next_word(acc_a), .parity_error(pe_a),
        .framing_error(fe_a), .overrun(ov_a)
    );

    uart_rx_framed #(
        .width(5), .baud_rate(9600), .clock_freq(460800),
        .parity_mode(NONE), .stop_bits(2)
    ) dut_b (
        .clock(clock), .resetn(resetn), .signal(line_b), .data(data_b),
        .ready(rdy_b), .can_receive_next_word(acc_b), .parity_error(pe_b),
        .framing_error(fe_b), .overrun(ov_b)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned stop_start, stop_end;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        logic [7:0]  d;
        logic        pe;
        logic        fe;
    } word_t;

    word_t q_a[$];
    word_t q_b[$];
    bit    mon_en  = 1'b1;
    bit    watch   = 1'b0;
    bit    dropped = 1'b0;
    int    ov_cnt_a = 0;
    int    ov_cnt_b = 0;

    always @(negedge clock) begin
        if (mon_en && rdy_a === 1'b1) q_a.push_back('{cyc, data_a, pe_a, fe_a});
        if (mon_en && rdy_b === 1'b1) q_b.push_back('{cyc, {3'b000, data_b}, pe_b, fe_b});
        if (ov_a === 1'b1) ov_cnt_a++;
        if (ov_b === 1'b1) ov_cnt_b++;
        if (watch && rdy_a !== 1'b1) dropped = 1'b1;
    end

    typedef struct {
        logic [7:0] value;
        logic       flip;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        check(name, {24'b0, act}, {24'b0, exp});
    endtask

    task automatic chki(input string name, input int act, input int exp);
        check(name, act, exp);
    endtask

    // Drive one frame; line changes on negedges. acc_off >= 0 pulses acc_a for
    // exactly that bit-time offset; abort_t >= 0 asserts reset at that offset.
    task automatic send(input int sel, input logic [8:0] v, input logic flip_par,
                        input logic stop_val, input bit glitch, input int acc_off,
                        input int abort_t);
        logic       fr[$];
        logic [8:0] sh;
        logic       b;
        int         nd, ns, first_stop, total;
        nd = (sel == 0) ? 8 : 5;
        ns = (sel == 0) ? 1 : 2;
        sh = v;
        fr.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            fr.push_back(sh[0]);
            sh = sh >> 1;
        end
        if (sel == 0) fr.push_back((^v[7:0]) ^ flip_par);
        first_stop = fr.size();
        for (int i = 0; i < ns; i++) fr.push_back(stop_val);
        total = fr.size() * TPB;
        for (int t = 0; t < total; t++) begin
            @(negedge clock);
            if (t == abort_t) begin
                resetn = 1'b0;
                line_a = 1'b1;
                line_b = 1'b1;
                return;
            end
            b = fr[t / TPB];
            if (glitch && (t % TPB) == 25) b = ~b;
            if (sel == 0) line_a = b;
            else          line_b = b;
            if (acc_off >= 0) acc_a = (t == acc_off);
            if (t == first_stop * TPB) stop_start = cyc;
            if (t == total - 1) stop_end = cyc + 1;
        end
    endtask

    task automatic check_frame(input int sel, input string tag, input logic [7:0] ed,
                               input logic epe, input logic efe);
        word_t w;
        int    n;
        n = (sel == 0) ? q_a.size() : q_b.size();
        chki({tag, "_ready_cycles"}, n, 1);
        if (n > 0) begin
            if (sel == 0) w = q_a[0];
            else          w = q_b[0];
            chk8({tag, "_data"}, w.d, ed);
            chk1({tag, "_parity_error"}, w.pe, epe);
            chk1({tag, "_framing_error"}, w.fe, efe);
            chk1({tag, "_ready_in_stop"}, (w.at >= stop_start) && (w.at < stop_end), 1'b1);
        end
        if (sel == 0) q_a.delete();
        else          q_b.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[1] = '{8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 8'h80, 1'b0, 1'b0};

        resetn = 1'b0;
        line_a = 1'b1;
        line_b = 1'b1;
        acc_a  = 1'b1;
        acc_b  = 1'b1;
        repeat (5) @(negedge clock);
        resetn = 1'b1;
        repeat (TPB) @(negedge clock);

        // 1. Reset state with idle line
        chk1("reset_ready_a", rdy_a, 1'b0);
        chk8("reset_data_a", data_a, 8'h00);
        chk1("reset_pe_a", pe_a, 1'b0);
        chk1("reset_fe_a", fe_a, 1'b0);
        chk1("reset_ov_a", ov_a, 1'b0);
        chk1("reset_ready_b", rdy_b, 1'b0);
        chk8("reset_data_b", {3'b000, data_b}, 8'h00);
        q_a.delete();
        q_b.delete();

        // 2. Sweep (even parity, 1 stop)
        for (int v = 0; v < 256; v += 5) begin
            send(0, 9'(v), 1'b0, 1'b1, 1'b0, -1, -1);
            check_frame(0, "sweep_a", 8'(v), 1'b0, 1'b0);
        end
        chki("sweep_a_overruns", ov_cnt_a, 0);

        // 2b. Sweep on 5-bit, no parity, 2 stop bits
        for (int v = 0; v < 32; v++) begin
            send(1, 9'(v), 1'b0, 1'b1, 1'b0, -1, -1);
            check_frame(1, "sweep_b", 8'(v), 1'b0, 1'b0);
        end
        chki("sweep_b_overruns", ov_cnt_b, 0);

        // 3. Table: parity error words and clean neighbours
        foreach (vecs[i]) begin
            send(0, {1'b0, vecs[i].value}, vecs[i].flip, 1'b1, 1'b0, -1, -1);
            check_frame(0, "table", vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe);
        end

        // 4. Framing error followed by a held-low break
        send(0, 9'h000, 1'b0, 1'b0, 1'b0, -1, -1);
        check_frame(0, "break", 8'h00, 1'b0, 1'b1);
        repeat (200) @(negedge clock);
        chki("break_no_retrigger", q_a.size(), 0);
        line_a = 1'b1;
        repeat (TPB) @(negedge clock);
        send(0, 9'h03C, 1'b0, 1'b1, 1'b0, -1, -1);
        check_frame(0, "after_break", 8'h3C, 1'b0, 1'b0);

        // 5. False start, then glitch tolerance
        @(negedge clock);
        line_a = 1'b0;
        repeat (10) @(negedge clock);
        line_a = 1'b1;
        repeat (3 * TPB) @(negedge clock);
        chki("false_start_no_ready", q_a.size(), 0);
        chk1("false_start_pe", pe_a, 1'b0);
        chk1("false_start_fe", fe_a, 1'b0);
        send(0, 9'h081, 1'b0, 1'b1, 1'b0, -1, -1);
        check_frame(0, "after_false_start", 8'h81, 1'b0, 1'b0);
        send(0, 9'h0F0, 1'b0, 1'b1, 1'b1, -1, -1);
        check_frame(0, "glitch", 8'hF0, 1'b0, 1'b0);

        // 6. Consumer stall, overrun, consume, accept on completion edge
        acc_a    = 1'b0;
        mon_en   = 1'b0;
        ov_cnt_a = 0;
        send(0, 9'h011, 1'b0, 1'b1, 1'b0, -1, -1);
        repeat (4) @(negedge clock);
        chk1("stall_ready", rdy_a, 1'b1);
        chk8("stall_data", data_a, 8'h11);
        send(0, 9'h022, 1'b0, 1'b1, 1'b0, -1, -1);
        repeat (4) @(negedge clock);
        chk8("overrun_data_kept", data_a, 8'h11);
        chk1("overrun_ready_kept", rdy_a, 1'b1);
        chki("overrun_pulses", ov_cnt_a, 1);
        acc_a = 1'b1;
        @(negedge clock);
        chk1("consume_ready_low", rdy_a, 1'b0);
        chk8("consume_data_kept", data_a, 8'h11);
        acc_a = 1'b0;
        send(0, 9'h033, 1'b0, 1'b1, 1'b0, -1, -1);
        repeat (4) @(negedge clock);
        chk8("held_33", data_a, 8'h33);
        ov_cnt_a = 0;
        dropped  = 1'b0;
        watch    = 1'b1;
        // completion edge for an 11-bit frame is 509 clocks after the start-bit edge
        send(0, 9'h044, 1'b0, 1'b1, 1'b0, 508, -1);
        repeat (4) @(negedge clock);
        watch = 1'b0;
        chk8("same_edge_data", data_a, 8'h44);
        chk1("same_edge_ready", rdy_a, 1'b1);
        chki("same_edge_no_overrun", ov_cnt_a, 0);
        chk1("same_edge_no_gap", dropped, 1'b0);
        acc_a = 1'b1;
        @(negedge clock);
        @(negedge clock);
        q_a.delete();
        mon_en = 1'b1;

        // 7. Reset during data bit 3
        send(0, 9'h096, 1'b0, 1'b1, 1'b0, -1, 4 * TPB + 20);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (TPB) @(negedge clock);
        chk8("midframe_reset_data", data_a, 8'h00);
        chk1("midframe_reset_ready", rdy_a, 1'b0);
        chk1("midframe_reset_pe", pe_a, 1'b0);
        chk1("midframe_reset_fe", fe_a, 1'b0);
        chk1("midframe_reset_ov", ov_a, 1'b0);
        chki("midframe_reset_no_word", q_a.size(), 0);
        send(0, 9'h0C3, 1'b0, 1'b1, 1'b0, -1, -1);
        check_frame(0, "after_reset", 8'hC3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
